spi_buffer: RTL and testbench
=============================

Name: spi_buffer

Overview:
- Host-side buffering stage placed directly upstream/downstream of the SPI shift engine (spiUnit).
- Contains a TX FIFO that feeds the engine's transmit handshake (transmitValid/dataRegIn/transmitReady).
- Contains an RX FIFO that captures each received word on the engine's receiveValid pulse.
- Lets the bus master queue back-to-back words so the engine streams continuously without gaps between words, and read results later.

Parameters:
- DATAWIDTH, 8, word width; must match the engine's DATAWIDTH.
- DEPTH, 16, entries per FIFO; power of two, 2 or greater.
- COUNTWIDTH, $clog2(DEPTH)+1, width of occupancy counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  active-low synchronous reset.
- wrValid  in  1  host offers TX word.
- wrData  in  DATAWIDTH  TX word from host.
- wrReady  out  1  TX FIFO can accept (not full).
- rdValid  out  1  RX FIFO holds a word (not empty).
- rdData  out  DATAWIDTH  RX FIFO head word (first-word-fall-through).
- rdReady  in  1  host consumes RX head.
- txFlush  in  1  empty TX FIFO.
- rxFlush  in  1  empty RX FIFO.
- rxEnable  in  1  1 = store received words; 0 = discard (transmit-only mode).
- overflowClear  in  1  clears rxOverflow.
- txCount  out  COUNTWIDTH  TX occupancy.
- rxCount  out  COUNTWIDTH  RX occupancy.
- rxOverflow  out  1  sticky: received word dropped because RX FIFO was full.
- transmitValid  out  1  to engine: TX word available.
- dataRegIn  out  DATAWIDTH  to engine: TX head word.
- transmitReady  in  1  from engine: accepts dataRegIn this cycle.
- receiveValid  in  1  from engine: dataReg holds a completed word this cycle.
- dataReg  in  DATAWIDTH  from engine: received word.

Behaviour:
- Reset: clk rising edge with reset low clears all pointers and counts to 0, rxOverflow to 0. Outputs after reset: wrReady=1, rdValid=0, transmitValid=0, txCount=0, rxCount=0. FIFO memory is not cleared; rdData and dataRegIn are don't-care while the matching valid is 0.
- TX push when wrValid && wrReady. wrReady = (txCount != DEPTH). There is no push-into-full even with a simultaneous pop.
- transmitValid = (txCount != 0). dataRegIn = TX head, combinational from the registered memory at the read pointer.
- TX pop when transmitValid && transmitReady. The engine pulses transmitReady for one cycle per accepted word. A ready pulse while the FIFO is empty is ignored.
- RX push when receiveValid && rxEnable && rxCount != DEPTH. dataReg is captured in that cycle.
- receiveValid && rxEnable && full: the word is dropped and rxOverflow is set on the next edge. rxEnable=0 discards the word without setting overflow.
- RX pop when rdValid && rdReady. rdValid = (rxCount != 0).
- Push and pop in the same cycle on a FIFO that is neither empty nor full: count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, natural wrap-around at DEPTH-1 -> 0.
- Counts update on the edge following the handshake. Latency is 1 cycle, e.g. a host write makes transmitValid rise on the next cycle.
- A word pushed into an empty RX FIFO is visible on rdData/rdValid in the cycle after the receiveValid pulse.
- Flush: txFlush/rxFlush zero that FIFO's pointers and count on the next edge. Flush has priority over a push or pop in the same cycle; a word pushed in the flush cycle is lost.
- rxFlush does not clear rxOverflow.
- overflowClear: clears rxOverflow on the next edge. If an overflow event occurs in the same cycle, set wins.
- The engine's receiveValid and transmitReady arrive together in its word-complete cycle. The RX push and TX pop then occur in that same cycle, independently.
- Reset asserted mid-transfer: FIFOs empty immediately. The engine has its own reset and must be reset together with this block; no partial-word recovery.

Decomposition:
- Package spi_pkg holds:
  - shared DATAWIDTH default;
  - a FIFO status struct (count, full, empty);
  - the engine handshake signal bundle typedef, shared with spiUnit wrappers.
- One sub-module, spi_fifo: synchronous FWFT FIFO with push/pop/flush, count, full and empty, parameterised by DATAWIDTH/DEPTH.
- spi_buffer instantiates spi_fifo twice and adds the overflow flag and rxEnable gating.

Test Plan:
- Reset low for 2 cycles with wrValid=1 -> no push; after release wrReady=1, txCount=0, transmitValid=0, rdValid=0, rxOverflow=0.
- Write 8'hA5, 8'h3C; pulse transmitReady twice, 3 cycles apart -> dataRegIn shows A5 then 3C; transmitValid drops after the second pulse; txCount goes 2 -> 1 -> 0.
- Fill TX with 16 words (0x00..0x0F) -> wrReady=0, txCount=16; a 17th write is ignored; pop all 16 -> order 0x00..0x0F, confirming pointer wrap.
- Pulse receiveValid 17 times with dataReg=0x10..0x20, rxEnable=1, no reads -> rxCount=16, rxOverflow=1; reads return 0x10..0x1F; pulse overflowClear -> rxOverflow=0.
- Same cycle: rdReady with RX count 5, and receiveValid with 8'h77 -> rxCount stays 5; 8'h77 is read last after the 4 older words.
- rxEnable=0 with receiveValid and dataReg=8'hFF -> rxCount unchanged, rxOverflow=0.
- txFlush together with wrValid at txCount=3 -> txCount=0, transmitValid=0 next cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI host buffer: FIFO status bundle and engine handshake flags.
package spi_pkg;
  localparam int SPI_DATAWIDTH = 8;
  localparam int FIFO_CNT_W    = 16;

  typedef struct packed {
    logic [FIFO_CNT_W-1:0] count;
    logic                  full;
    logic                  empty;
  } fifoStatus_t;

  // Per-cycle handshake flags exchanged with spiUnit
  typedef struct packed {
    logic transmitValid;
    logic transmitReady;
    logic receiveValid;
  } spiHandshake_t;
endpackage

// File: rtl/spi_buffer_if.sv
// Host and engine side signals of spi_buffer; slave is the buffer's view.
interface spi_buffer_if #(
  parameter int DATAWIDTH  = spi_pkg::SPI_DATAWIDTH,
  parameter int DEPTH      = 16,
  parameter int COUNTWIDTH = $clog2(DEPTH) + 1
);
  logic                  wrValid;
  logic [DATAWIDTH-1:0]  wrData;
  logic                  wrReady;
  logic                  rdValid;
  logic [DATAWIDTH-1:0]  rdData;
  logic                  rdReady;
  logic                  txFlush;
  logic                  rxFlush;
  logic                  rxEnable;
  logic                  overflowClear;
  logic [COUNTWIDTH-1:0] txCount;
  logic [COUNTWIDTH-1:0] rxCount;
  logic                  rxOverflow;
  logic                  transmitValid;
  logic [DATAWIDTH-1:0]  dataRegIn;
  logic                  transmitReady;
  logic                  receiveValid;
  logic [DATAWIDTH-1:0]  dataReg;

  modport slave (
    input  wrValid, wrData, rdReady, txFlush, rxFlush, rxEnable, overflowClear,
           transmitReady, receiveValid, dataReg,
    output wrReady, rdValid, rdData, txCount, rxCount, rxOverflow,
           transmitValid, dataRegIn
  );

  modport master (
    output wrValid, wrData, rdReady, txFlush, rxFlush, rxEnable, overflowClear,
           transmitReady, receiveValid, dataReg,
    input  wrReady, rdValid, rdData, txCount, rxCount, rxOverflow,
           transmitValid, dataRegIn
  );
endinterface

// File: rtl/spi_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; push into full and pop from empty are dropped.
module spi_fifo import spi_pkg::*; #(
  parameter int DATAWIDTH = SPI_DATAWIDTH,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] wrData,
  output logic [DATAWIDTH-1:0] rdData,
  output fifoStatus_t          status
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wrPtr, rdPtr;
  logic [CW-1:0]        count;
  logic                 full, empty, doPush, doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdData = mem[rdPtr];
  assign status = '{count: FIFO_CNT_W'(count), full: full, empty: empty};
endmodule

// File: rtl/spi_buffer.sv
// Host-side TX/RX buffering around the SPI shift engine, with sticky RX overflow flag.
module spi_buffer import spi_pkg::*; #(
  parameter int DATAWIDTH  = SPI_DATAWIDTH,
  parameter int DEPTH      = 16,
  parameter int COUNTWIDTH = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        reset,
  spi_buffer_if.slave bus
);
  fifoStatus_t   txStat, rxStat;
  spiHandshake_t eng;
  logic          rxGo, rxDrop, rxOverflowQ;

  assign eng = '{transmitValid: !txStat.empty,
                 transmitReady: bus.transmitReady,
                 receiveValid:  bus.receiveValid};

  spi_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH)) txFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (bus.wrValid),
    .pop    (eng.transmitReady),
    .flush  (bus.txFlush),
    .wrData (bus.wrData),
    .rdData (bus.dataRegIn),
    .status (txStat)
  );

  // Words arriving with rxEnable low are discarded silently (transmit-only mode)
  assign rxGo   = eng.receiveValid && bus.rxEnable;
  assign rxDrop = rxGo && rxStat.full;

  spi_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH)) rxFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (rxGo),
    .pop    (bus.rdReady),
    .flush  (bus.rxFlush),
    .wrData (bus.dataReg),
    .rdData (bus.rdData),
    .status (rxStat)
  );

  // A drop in the same cycle as overflowClear keeps the flag set
  always_ff @(posedge clk) begin
    if (!reset)                 rxOverflowQ <= 1'b0;
    else if (rxDrop)            rxOverflowQ <= 1'b1;
    else if (bus.overflowClear) rxOverflowQ <= 1'b0;
  end

  assign bus.wrReady       = !txStat.full;
  assign bus.transmitValid = eng.transmitValid;
  assign bus.rdValid       = !rxStat.empty;
  assign bus.txCount       = COUNTWIDTH'(txStat.count);
  assign bus.rxCount       = COUNTWIDTH'(rxStat.count);
  assign bus.rxOverflow    = rxOverflowQ;
endmodule

// File: tb/tb_spi_buffer.sv
// Bench for spi_buffer: directed vector table, corner sequences, then random traffic against a queue model.
module tb_spi_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          wrValid;
    logic [DW-1:0] wrData;
    logic          rdReady;
    logic          txFlush;
    logic          rxFlush;
    logic          rxEnable;
    logic          ovClr;
    logic          tReady;
    logic          rValid;
    logic [DW-1:0] dReg;
  } in_t;

  typedef struct {
    in_t           i;
    int            eTx;
    int            eRx;
    bit            eOvf;
    logic [DW-1:0] eHead;
    logic [DW-1:0] eRd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  logic [DW-1:0] txQ[$];
  logic [DW-1:0] rxQ[$];
  bit            ovf;

  always #5 clk = ~clk;

  spi_buffer_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

  spi_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic in_t mkIn(bit wv, logic [DW-1:0] wd, bit rr, bit tf, bit rf, bit re,
                               bit oc, bit tr, bit rv, logic [DW-1:0] dr);
    in_t v;
    v = '{wrValid: wv, wrData: wd, rdReady: rr, txFlush: tf, rxFlush: rf, rxEnable: re,
          ovClr: oc, tReady: tr, rValid: rv, dReg: dr};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    bus.wrValid       = v.wrValid;
    bus.wrData        = v.wrData;
    bus.rdReady       = v.rdReady;
    bus.txFlush       = v.txFlush;
    bus.rxFlush       = v.rxFlush;
    bus.rxEnable      = v.rxEnable;
    bus.overflowClear = v.ovClr;
    bus.transmitReady = v.tReady;
    bus.receiveValid  = v.rValid;
    bus.dataReg       = v.dReg;
  endtask

  // Reference behaviour from the FIFO rules, applied to the pre-edge state
  task automatic modelStep(input in_t v);
    bit txFull, txPush, txPop, rxFull, rxGo, rxPop;
    txFull = (txQ.size() == DEPTH);
    txPush = v.wrValid && !txFull;
    txPop  = v.tReady && (txQ.size() != 0);
    rxFull = (rxQ.size() == DEPTH);
    rxGo   = v.rValid && v.rxEnable;
    rxPop  = v.rdReady && (rxQ.size() != 0);
    if (rxGo && rxFull) ovf = 1'b1;
    else if (v.ovClr)   ovf = 1'b0;
    if (v.txFlush) txQ.delete();
    else begin
      if (txPop)  void'(txQ.pop_front());
      if (txPush) txQ.push_back(v.wrData);
    end
    if (v.rxFlush) rxQ.delete();
    else begin
      if (rxPop)          void'(rxQ.pop_front());
      if (rxGo && !rxFull) rxQ.push_back(v.dReg);
    end
  endtask

  task automatic modelCheck();
    chk("txCount", 32'(bus.txCount), txQ.size());
    chk("rxCount", 32'(bus.rxCount), rxQ.size());
    chk("rxOverflow", 32'(bus.rxOverflow), 32'(ovf));
    chk("wrReady", 32'(bus.wrReady), 32'(txQ.size() != DEPTH));
    chk("transmitValid", 32'(bus.transmitValid), 32'(txQ.size() != 0));
    chk("rdValid", 32'(bus.rdValid), 32'(rxQ.size() != 0));
    if (txQ.size() != 0) chk("dataRegIn", 32'(bus.dataRegIn), 32'(txQ[0]));
    if (rxQ.size() != 0) chk("rdData", 32'(bus.rdData), 32'(rxQ[0]));
  endtask

  task automatic cyc(input in_t v);
    drive(v);
    @(posedge clk);
    modelStep(v);
    #1;
    modelCheck();
  endtask

  task automatic doReset(input bit wv);
    drive(mkIn(wv, 8'h5A, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    txQ.delete();
    rxQ.delete();
    ovf = 1'b0;
    #1;
    chk("rst txCount", 32'(bus.txCount), 0);
    chk("rst rxCount", 32'(bus.rxCount), 0);
    chk("rst wrReady", 32'(bus.wrReady), 1);
    chk("rst transmitValid", 32'(bus.transmitValid), 0);
    chk("rst rdValid", 32'(bus.rdValid), 0);
    chk("rst rxOverflow", 32'(bus.rxOverflow), 0);
    reset = 1'b1;
  endtask

  vec_t tbl[22];
  in_t  idle, v;

  initial begin
    reset = 1'b0;
    idle  = mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    //                  wv wd    rr tf rf re oc tr rv dr        tx rx ov head   rd
    tbl[0]  = '{mkIn(1, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 8'h00), 1, 0, 0, 8'hA5, 8'h00};
    tbl[1]  = '{mkIn(1, 8'h3C, 0, 0, 0, 1, 0, 0, 0, 8'h00), 2, 0, 0, 8'hA5, 8'h00};
    tbl[2]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00), 2, 0, 0, 8'hA5, 8'h00};
    tbl[3]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00), 1, 0, 0, 8'h3C, 8'h00};
    tbl[4]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00), 1, 0, 0, 8'h3C, 8'h00};
    tbl[5]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00), 1, 0, 0, 8'h3C, 8'h00};
    tbl[6]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};
    tbl[7]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};
    tbl[8]  = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h77), 0, 1, 0, 8'h00, 8'h77};
    tbl[9]  = '{mkIn(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'hFF), 0, 1, 0, 8'h00, 8'h77};
    tbl[10] = '{mkIn(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};
    tbl[11] = '{mkIn(1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 8'h00), 1, 0, 0, 8'h11, 8'h00};
    tbl[12] = '{mkIn(1, 8'h22, 0, 0, 0, 1, 0, 0, 0, 8'h00), 2, 0, 0, 8'h11, 8'h00};
    tbl[13] = '{mkIn(1, 8'h33, 0, 0, 0, 1, 0, 0, 0, 8'h00), 3, 0, 0, 8'h11, 8'h00};
    tbl[14] = '{mkIn(1, 8'h44, 0, 1, 0, 1, 0, 0, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};
    tbl[15] = '{mkIn(1, 8'h55, 0, 0, 0, 1, 0, 1, 0, 8'h00), 1, 0, 0, 8'h55, 8'h00};
    tbl[16] = '{mkIn(1, 8'h66, 0, 0, 0, 1, 0, 1, 0, 8'h00), 1, 0, 0, 8'h66, 8'h00};
    tbl[17] = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};
    tbl[18] = '{mkIn(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h12), 0, 0, 0, 8'h00, 8'h00};
    tbl[19] = '{mkIn(0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h34), 0, 1, 0, 8'h00, 8'h34};
    tbl[20] = '{mkIn(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h56), 0, 1, 0, 8'h00, 8'h56};
    tbl[21] = '{mkIn(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00), 0, 0, 0, 8'h00, 8'h00};

    doReset(1'b1);

    for (int k = 0; k < 22; k++) begin
      cyc(tbl[k].i);
      chk($sformatf("tbl%0d txCount", k), 32'(bus.txCount), tbl[k].eTx);
      chk($sformatf("tbl%0d rxCount", k), 32'(bus.rxCount), tbl[k].eRx);
      chk($sformatf("tbl%0d rxOverflow", k), 32'(bus.rxOverflow), 32'(tbl[k].eOvf));
      if (tbl[k].eTx != 0) chk($sformatf("tbl%0d dataRegIn", k), 32'(bus.dataRegIn), 32'(tbl[k].eHead));
      if (tbl[k].eRx != 0) chk($sformatf("tbl%0d rdData", k), 32'(bus.rdData), 32'(tbl[k].eRd));
    end

    // TX fill to full, rejected 17th write, drain in order across the pointer wrap
    for (int k = 0; k < DEPTH; k++) begin
      v = idle; v.wrValid = 1; v.wrData = DW'(k); cyc(v);
    end
    chk("fill txCount", 32'(bus.txCount), DEPTH);
    chk("fill wrReady", 32'(bus.wrReady), 0);
    v = idle; v.wrValid = 1; v.wrData = 8'hEE; cyc(v);
    chk("17th txCount", 32'(bus.txCount), DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d dataRegIn", k), 32'(bus.dataRegIn), k);
      v = idle; v.tReady = 1; cyc(v);
    end
    chk("drain transmitValid", 32'(bus.transmitValid), 0);

    // RX overflow: 17 words, set beats clear, then clear alone, then ordered reads
    for (int k = 0; k < DEPTH + 1; k++) begin
      v = idle; v.rValid = 1; v.dReg = DW'(8'h10 + k); cyc(v);
    end
    chk("ovf rxCount", 32'(bus.rxCount), DEPTH);
    chk("ovf flag", 32'(bus.rxOverflow), 1);
    v = idle; v.rValid = 1; v.dReg = 8'h99; v.ovClr = 1; cyc(v);
    chk("ovf set wins", 32'(bus.rxOverflow), 1);
    v = idle; v.ovClr = 1; cyc(v);
    chk("ovf cleared", 32'(bus.rxOverflow), 0);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("rxread%0d", k), 32'(bus.rdData), 32'h10 + k);
      v = idle; v.rdReady = 1; cyc(v);
    end

    // Simultaneous RX push and pop at count 5
    for (int k = 0; k < 5; k++) begin
      v = idle; v.rValid = 1; v.dReg = DW'(8'hA0 + k); cyc(v);
    end
    v = idle; v.rValid = 1; v.dReg = 8'h77; v.rdReady = 1; cyc(v);
    chk("pushpop rxCount", 32'(bus.rxCount), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pushpop read%0d", k), 32'(bus.rdData), (k == 4) ? 32'h77 : 32'hA1 + k);
      v = idle; v.rdReady = 1; cyc(v);
    end

    // Engine word-complete cycle: RX push and TX pop together
    v = idle; v.wrValid = 1; v.wrData = 8'hC1; cyc(v);
    v = idle; v.tReady = 1; v.rValid = 1; v.dReg = 8'hD2; cyc(v);
    chk("engine txCount", 32'(bus.txCount), 0);
    chk("engine rdData", 32'(bus.rdData), 32'hD2);

    // Reset with traffic in flight empties both FIFOs
    for (int k = 0; k < 3; k++) begin
      v = idle; v.wrValid = 1; v.wrData = DW'(k); v.rValid = 1; v.dReg = DW'(k); cyc(v);
    end
    doReset(1'b1);

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      v.wrValid  = ($urandom_range(0, 99) < 50);
      v.wrData   = DW'($urandom);
      v.rdReady  = ($urandom_range(0, 99) < 40);
      v.txFlush  = ($urandom_range(0, 99) < 2);
      v.rxFlush  = ($urandom_range(0, 99) < 2);
      v.rxEnable = ($urandom_range(0, 99) < 90);
      v.ovClr    = ($urandom_range(0, 99) < 5);
      v.tReady   = ($urandom_range(0, 99) < 40);
      v.rValid   = ($urandom_range(0, 99) < 45);
      v.dReg     = DW'($urandom);
      cyc(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
